p_hit_t_div: RTL and testbench

- Parametrised successor to the ray/plane hit stage of the ray tracer.
- Accepts one ray plus one triangle plane (normal, v0) per write through an input FIFO.
- Computes the hit distance t = dot(n, v0-origin) / dot(n, dir) in signed fixed point using an iterative divider, and classifies each ray as hit or miss.
- Writes {t, hit} to a show-ahead output FIFO read by the next ray-tracer stage.

---
 rtl/p_hit_t_div.sv | 241 ++++++++++++++++++++++++
 tb/tb_p_hit_t_div.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_hit_t_div.sv
// p_hit_t_div: ray/plane hit-distance stage.
// Computes t = dot(n, v0 - origin) / dot(n, dir) in signed fixed point
// (WIDTH bits, Q_BITS fractional) and classifies each ray as hit or miss.
// Jobs enter through an input FIFO; a multi-cycle engine (one job at a time)
// writes {t, hit} into a show-ahead output FIFO.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   normal, v0, origin, dir  three WIDTH-bit signed coordinates each, sampled on in_wr_en
//   in_wr_en / in_full       input FIFO push / full flag
//   out_t, out_hit           head entry of the output FIFO (0 when empty)
//   out_rd_en / out_empty    output FIFO pop / empty flag
//   busy                     engine is working on a job
module p_hit_t_div #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned Q_BITS        = 16,
   parameter int unsigned IN_DEPTH      = 16,
   parameter int unsigned OUT_DEPTH     = 16,
   parameter bit          CULL_BACKFACE = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2:0][WIDTH-1:0] normal,
   input  logic [2:0][WIDTH-1:0] v0,
   input  logic [2:0][WIDTH-1:0] origin,
   input  logic [2:0][WIDTH-1:0] dir,
   input  logic                  in_wr_en,
   output logic                  in_full,
   output logic [WIDTH-1:0]      out_t,
   output logic                  out_hit,
   input  logic                  out_rd_en,
   output logic                  out_empty,
   output logic                  busy
);

   localparam int unsigned JW  = 12 * WIDTH;
   localparam int unsigned IAW = $clog2(IN_DEPTH);
   localparam int unsigned OAW = $clog2(OUT_DEPTH);
   localparam int unsigned PW  = 2 * WIDTH + 1;
   localparam int unsigned SW  = 2 * WIDTH + 3;
   localparam int unsigned LW  = WIDTH + Q_BITS;
   localparam int unsigned CW  = $clog2(LW + 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StDot   = 3'd2;
   localparam logic [2:0] StSum   = 3'd3;
   localparam logic [2:0] StDiv   = 3'd4;
   localparam logic [2:0] StWrite = 3'd5;

   logic [2:0]            state_q, state_d;

   logic [JW-1:0]         in_mem [IN_DEPTH];
   logic [IAW:0]          in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic                  in_empty, in_push, in_pop;

   logic [JW-1:0]         job_q, job_d;
   logic [2:0][WIDTH-1:0] j_nrm, j_v0, j_org, j_dir;
   logic [2:0][WIDTH:0]   diff_q, diff_d;
   logic [2:0][PW-1:0]    pd_q, pd_d, pn_q, pn_d;
   logic signed [SW-1:0]  sum_den, sum_num, den, num;
   logic [SW-1:0]         abs_den, abs_num, num_hi;
   logic                  miss;

   logic [SW-1:0]         dvs_q, dvs_d, rem_q, rem_d, rem_step;
   logic [SW:0]           rem_shift;
   logic [LW-1:0]         lo_q, lo_d, lo_step;
   logic                  q_bit;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic [WIDTH-1:0]      t_q, t_d;
   logic                  hit_q, hit_d;

   logic [WIDTH:0]        out_mem [OUT_DEPTH];
   logic [OAW:0]          out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic                  out_full, out_push, out_pop;
   logic [WIDTH:0]        out_head;

   // FIFO flags: pointers carry one extra wrap bit
   assign in_empty  = in_wp_q == in_rp_q;
   assign in_full   = (in_wp_q[IAW] != in_rp_q[IAW]) &&
                      (in_wp_q[IAW-1:0] == in_rp_q[IAW-1:0]);
   assign in_pop    = (state_q == StIdle) && !in_empty;
   assign in_push   = in_wr_en && (!in_full || in_pop);

   assign out_empty = out_wp_q == out_rp_q;
   assign out_full  = (out_wp_q[OAW] != out_rp_q[OAW]) &&
                      (out_wp_q[OAW-1:0] == out_rp_q[OAW-1:0]);
   assign out_pop   = out_rd_en && !out_empty;
   assign out_push  = (state_q == StWrite) && (!out_full || out_pop);
   assign out_head  = out_mem[out_rp_q[OAW-1:0]];
   assign out_t     = out_empty ? '0 : out_head[WIDTH:1];
   assign out_hit   = out_empty ? 1'b0 : out_head[0];

   assign busy = state_q != StIdle;
   assign {j_nrm, j_v0, j_org, j_dir} = job_q;

   // Dot-product sums and hit/miss classification
   always_comb begin
      sum_den = '0;
      sum_num = '0;
      for (int i = 0; i < 3; i++) begin
         sum_den = sum_den + SW'($signed(pd_q[i]));
         sum_num = sum_num + SW'($signed(pn_q[i]));
      end
      den     = sum_den >>> Q_BITS;
      num     = sum_num >>> Q_BITS;
      abs_den = den[SW-1] ? -den : den;
      abs_num = num[SW-1] ? -num : num;
      num_hi  = abs_num >> WIDTH;
      miss    = (den == '0) || ((num != '0) && (num[SW-1] != den[SW-1])) ||
                (CULL_BACKFACE && !den[SW-1]);
   end

   // One restoring-divide step; lo_q feeds dividend bits out the top and
   // collects quotient bits at the bottom.
   always_comb begin
      rem_shift = {rem_q, lo_q[LW-1]};
      q_bit     = rem_shift >= {1'b0, dvs_q};
      rem_step  = q_bit ? rem_shift[SW-1:0] - dvs_q : rem_shift[SW-1:0];
      lo_step   = {lo_q[LW-2:0], q_bit};
   end

   always_comb begin
      state_d  = state_q;
      in_wp_d  = in_wp_q + (IAW+1)'(in_push);
      in_rp_d  = in_rp_q + (IAW+1)'(in_pop);
      out_wp_d = out_wp_q + (OAW+1)'(out_push);
      out_rp_d = out_rp_q + (OAW+1)'(out_pop);
      job_d    = job_q;
      diff_d   = diff_q;
      pd_d     = pd_q;
      pn_d     = pn_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      t_d      = t_q;
      hit_d    = hit_q;
      case (state_q)
         StIdle: begin
            if (in_pop) begin
               job_d   = in_mem[in_rp_q[IAW-1:0]];
               state_d = StLoad;
            end
         end
         StLoad: begin
            for (int i = 0; i < 3; i++) begin
               diff_d[i] = {j_v0[i][WIDTH-1], j_v0[i]} - {j_org[i][WIDTH-1], j_org[i]};
            end
            state_d = StDot;
         end
         StDot: begin
            for (int i = 0; i < 3; i++) begin
               pd_d[i] = PW'($signed(j_nrm[i])) * PW'($signed(j_dir[i]));
               pn_d[i] = PW'($signed(j_nrm[i])) * PW'($signed(diff_q[i]));
            end
            state_d = StSum;
         end
         StSum: begin
            if (miss) begin
               t_d     = '0;
               hit_d   = 1'b0;
               state_d = StWrite;
            end else begin
               // Dividend is |num| << Q_BITS; its bits above LW only matter as an
               // overflow test, so they seed the remainder directly.
               dvs_d   = abs_den;
               rem_d   = num_hi;
               ovf_d   = num_hi >= abs_den;
               lo_d    = {abs_num[WIDTH-1:0], {Q_BITS{1'b0}}};
               cnt_d   = CW'(LW - 1);
               state_d = StDiv;
            end
         end
         StDiv: begin
            rem_d = rem_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               hit_d   = 1'b1;
               t_d     = (ovf_q || (|lo_step[LW-1:WIDTH-1])) ?
                         {1'b0, {(WIDTH-1){1'b1}}} : lo_step[WIDTH-1:0];
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (out_push) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         in_wp_q  <= '0;
         in_rp_q  <= '0;
         out_wp_q <= '0;
         out_rp_q <= '0;
         job_q    <= '0;
         diff_q   <= '0;
         pd_q     <= '0;
         pn_q     <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         t_q      <= '0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_wp_q  <= in_wp_d;
         in_rp_q  <= in_rp_d;
         out_wp_q <= out_wp_d;
         out_rp_q <= out_rp_d;
         job_q    <= job_d;
         diff_q   <= diff_d;
         pd_q     <= pd_d;
         pn_q     <= pn_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         t_q      <= t_d;
         hit_q    <= hit_d;
      end
   end

   // FIFO storage needs no reset: contents are only visible through the pointers
   always_ff @(posedge clock) begin
      if (in_push) in_mem[in_wp_q[IAW-1:0]] <= {normal, v0, origin, dir};
   end

   always_ff @(posedge clock) begin
      if (out_push) out_mem[out_wp_q[OAW-1:0]] <= {t_q, hit_q};
   end

endmodule

// File: tb/tb_p_hit_t_div.sv
// Bench for p_hit_t_div: one default instance and one with back-face culling.
module tb_p_hit_t_div;
   localparam int W = 32;
   localparam int Q = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [2:0][W-1:0] normal = '0;
   logic [2:0][W-1:0] v0 = '0;
   logic [2:0][W-1:0] origin = '0;
   logic [2:0][W-1:0] dir = '0;
   logic              wr_en [2] = '{1'b0, 1'b0};
   logic              rd_en [2] = '{1'b0, 1'b0};
   logic              in_full [2];
   logic [W-1:0]      out_t [2];
   logic              out_hit [2];
   logic              out_empty [2];
   logic              busy [2];
   int                n_cmp = 0;
   int                n_bad = 0;

   always #5 clock = ~clock;

   p_hit_t_div #(.WIDTH(W), .Q_BITS(Q), .IN_DEPTH(16), .OUT_DEPTH(16), .CULL_BACKFACE(1'b0)) dut (
      .clock(clock), .reset(reset), .normal(normal), .v0(v0), .origin(origin), .dir(dir),
      .in_wr_en(wr_en[0]), .in_full(in_full[0]), .out_t(out_t[0]), .out_hit(out_hit[0]),
      .out_rd_en(rd_en[0]), .out_empty(out_empty[0]), .busy(busy[0]));

   p_hit_t_div #(.WIDTH(W), .Q_BITS(Q), .IN_DEPTH(16), .OUT_DEPTH(16), .CULL_BACKFACE(1'b1))
   dut_cull (
      .clock(clock), .reset(reset), .normal(normal), .v0(v0), .origin(origin), .dir(dir),
      .in_wr_en(wr_en[1]), .in_full(in_full[1]), .out_t(out_t[1]), .out_hit(out_hit[1]),
      .out_rd_en(rd_en[1]), .out_empty(out_empty[1]), .busy(busy[1]));

   // Reference: exact rational arithmetic at 128 bits, returns {t, hit}
   function automatic logic [W:0] ref_out(input logic [2:0][W-1:0] n, v, o, d, input bit cull);
      logic signed [127:0] a, b, c, sd, sn, den, num, an, ad, q;
      sd = '0;
      sn = '0;
      for (int i = 0; i < 3; i++) begin
         a  = $signed(n[i]);
         b  = $signed(d[i]);
         sd = sd + a * b;
         b  = $signed(v[i]);
         c  = $signed(o[i]);
         sn = sn + a * (b - c);
      end
      den = sd >>> Q;
      num = sn >>> Q;
      if (den == 0 || (num != 0 && ((num < 0) != (den < 0))) || (cull && den >= 0)) return '0;
      an = (num < 0) ? -num : num;
      ad = (den < 0) ? -den : den;
      q  = (an << Q) / ad;
      if (q > 128'sh7FFF_FFFF) return {32'h7FFF_FFFF, 1'b1};
      return {q[W-1:0], 1'b1};
   endfunction

   function automatic logic [W-1:0] rcoord();
      int v;
      case ($urandom_range(0, 4))
         0: v = 0;
         1: v = int'($urandom_range(0, 1048576)) - 524288;
         2: v = (int'($urandom_range(0, 16)) - 8) * 65536;
         3: v = int'($urandom());
         default: v = int'($urandom_range(0, 255));
      endcase
      return v;
   endfunction

   task automatic set_random_job();
      for (int c = 0; c < 3; c++) begin
         normal[c] = rcoord();
         v0[c]     = rcoord();
         origin[c] = rcoord();
         dir[c]    = rcoord();
      end
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic push(input int idx);
      wr_en[idx] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      wr_en[idx] = 1'b0;
   endtask

   task automatic pop(input int idx);
      rd_en[idx] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rd_en[idx] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         n_cmp += 5;
         if (in_full[i] !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_full[%0d]: got %b want 0", i, in_full[i]);
         end
         if (out_empty[i] !== 1'b1) begin
            n_bad++; $display("FAIL reset_out_empty[%0d]: got %b want 1", i, out_empty[i]);
         end
         if (out_t[i] !== '0) begin
            n_bad++; $display("FAIL reset_out_t[%0d]: got %h want 0", i, out_t[i]);
         end
         if (out_hit[i] !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_hit[%0d]: got %b want 0", i, out_hit[i]);
         end
         if (busy[i] !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]);
         end
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (busy[i] !== 1'b0 || out_empty[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_idle[%0d]: busy=%b empty=%b want 0/1", i, busy[i],
                     out_empty[i]);
         end
      end
   endtask

   typedef struct {
      int           idx;
      logic [W-1:0] nz, vz, dz, et;
      logic         eh;
      int           lat;
   } dvec_t;

   task automatic test_directed();
      dvec_t tbl [8];
      int    g, lat;
      tbl[0] = '{0, 32'h0001_0000, 32'h0005_0000, 32'h0001_0000, 32'h0005_0000, 1'b1, 52};
      tbl[1] = '{0, 32'h0001_0000, 32'h0005_0000, 32'h0002_0000, 32'h0002_8000, 1'b1, 52};
      tbl[2] = '{0, 32'h0001_0000, 32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4};
      tbl[3] = '{0, 32'h0001_0000, 32'h0005_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 4};
      tbl[4] = '{1, 32'h0001_0000, 32'h0005_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 4};
      tbl[5] = '{1, 32'hFFFF_0000, 32'h0005_0000, 32'h0001_0000, 32'h0005_0000, 1'b1, 52};
      tbl[6] = '{0, 32'h0001_0000, 32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 52};
      tbl[7] = '{0, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 52};
      foreach (tbl[k]) begin
         normal    = '0;
         v0        = '0;
         origin    = '0;
         dir       = '0;
         normal[2] = tbl[k].nz;
         v0[2]     = tbl[k].vz;
         dir[2]    = tbl[k].dz;
         push(tbl[k].idx);
         g = 0;
         while (!busy[tbl[k].idx] && g < 10) begin
            @(posedge clock); @(negedge clock); g++;
         end
         lat = 0;
         while (out_empty[tbl[k].idx] && lat < 200) begin
            @(posedge clock); @(negedge clock); lat++;
         end
         n_cmp += 4;
         if (lat != tbl[k].lat) begin
            n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, tbl[k].lat);
         end
         if (out_t[tbl[k].idx] !== tbl[k].et) begin
            n_bad++;
            $display("FAIL dir%0d_t: got %h want %h", k, out_t[tbl[k].idx], tbl[k].et);
         end
         if (out_hit[tbl[k].idx] !== tbl[k].eh) begin
            n_bad++;
            $display("FAIL dir%0d_hit: got %b want %b", k, out_hit[tbl[k].idx], tbl[k].eh);
         end
         if (busy[tbl[k].idx] !== 1'b0) begin
            n_bad++; $display("FAIL dir%0d_busy_after: got %b want 0", k, busy[tbl[k].idx]);
         end
         pop(tbl[k].idx);
         n_cmp++;
         if (out_empty[tbl[k].idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL dir%0d_empty_after_pop: got %b want 1", k, out_empty[tbl[k].idx]);
         end
      end
   endtask

   task automatic test_random();
      logic [W:0] exp_q [$];
      logic [W:0] e;
      int         g, nj;
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 4; r++) begin
            nj = $urandom_range(1, 12);
            for (int k = 0; k < nj; k++) begin
               set_random_job();
               exp_q.push_back(ref_out(normal, v0, origin, dir, i == 1));
               push(i);
            end
            while (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               g = 0;
               while (out_empty[i] && g < 400) begin
                  @(posedge clock); @(negedge clock); g++;
               end
               n_cmp++;
               if (out_empty[i]) begin
                  n_bad++;
                  $display("FAIL rand_timeout[%0d]: no result, %0d left", i, exp_q.size() + 1);
                  exp_q.delete();
                  break;
               end
               if ({out_t[i], out_hit[i]} !== e) begin
                  n_bad++;
                  $display("FAIL rand_result[%0d]: got t=%h hit=%b want t=%h hit=%b", i,
                           out_t[i], out_hit[i], e[W:1], e[0]);
               end
               repeat ($urandom_range(0, 2)) @(negedge clock);
               pop(i);
            end
            repeat (60) @(negedge clock);
            n_cmp++;
            if (out_empty[i] !== 1'b1 || busy[i] !== 1'b0) begin
               n_bad++;
               $display("FAIL rand_drained[%0d]: empty=%b busy=%b want 1/0", i, out_empty[i],
                        busy[i]);
            end
         end
      end
   endtask

   // Output side blocked: 16 results fill the output FIFO, one stalls in WRITE,
   // 16 more wait in the input FIFO, the last 7 writes are dropped.
   task automatic test_fill();
      logic [W:0] exp_q [$];
      logic [W:0] e;
      int         g;
      for (int k = 0; k < 40; k++) begin
         set_random_job();
         if (k < 33) exp_q.push_back(ref_out(normal, v0, origin, dir, 1'b0));
         push(0);
         repeat (59) @(negedge clock);
      end
      n_cmp += 3;
      if (in_full[0] !== 1'b1) begin
         n_bad++; $display("FAIL fill_in_full: got %b want 1", in_full[0]);
      end
      if (busy[0] !== 1'b1) begin
         n_bad++; $display("FAIL fill_stalled_busy: got %b want 1", busy[0]);
      end
      if (out_empty[0] !== 1'b0) begin
         n_bad++; $display("FAIL fill_out_empty: got %b want 0", out_empty[0]);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 0;
         while (out_empty[0] && g < 400) begin
            @(posedge clock); @(negedge clock); g++;
         end
         n_cmp++;
         if (out_empty[0]) begin
            n_bad++; $display("FAIL fill_timeout: %0d results missing", exp_q.size() + 1);
            exp_q.delete();
            break;
         end
         if ({out_t[0], out_hit[0]} !== e) begin
            n_bad++;
            $display("FAIL fill_result: got t=%h hit=%b want t=%h hit=%b", out_t[0],
                     out_hit[0], e[W:1], e[0]);
         end
         pop(0);
      end
      repeat (150) @(negedge clock);
      n_cmp += 2;
      if (out_empty[0] !== 1'b1) begin
         n_bad++; $display("FAIL fill_no_extra: out_empty got %b want 1", out_empty[0]);
      end
      if (busy[0] !== 1'b0 || in_full[0] !== 1'b0) begin
         n_bad++; $display("FAIL fill_idle: busy=%b in_full=%b want 0/0", busy[0], in_full[0]);
      end
   endtask

   task automatic test_reset_mid_div();
      int g;
      normal    = '0;
      v0        = '0;
      origin    = '0;
      dir       = '0;
      normal[2] = 32'h0001_0000;
      v0[2]     = 32'h0005_0000;
      push(0);
      g = 0;
      while (out_empty[0] && g < 50) begin
         @(posedge clock); @(negedge clock); g++;
      end
      n_cmp++;
      if (out_empty[0] !== 1'b0) begin
         n_bad++; $display("FAIL rst_pre_result: out_empty got %b want 0", out_empty[0]);
      end
      dir[2] = 32'h0001_0000;
      push(0);
      push(0);
      repeat (20) @(negedge clock);
      n_cmp++;
      if (busy[0] !== 1'b1) begin
         n_bad++; $display("FAIL rst_busy_in_div: got %b want 1", busy[0]);
      end
      reset = 1'b1;
      #1;
      n_cmp += 3;
      if (out_empty[0] !== 1'b1) begin
         n_bad++; $display("FAIL rst_out_empty: got %b want 1", out_empty[0]);
      end
      if (busy[0] !== 1'b0) begin
         n_bad++; $display("FAIL rst_busy: got %b want 0", busy[0]);
      end
      if (out_t[0] !== '0 || out_hit[0] !== 1'b0) begin
         n_bad++; $display("FAIL rst_out_value: got t=%h hit=%b want 0/0", out_t[0], out_hit[0]);
      end
      @(negedge clock);
      reset  = 1'b0;
      @(negedge clock);
      dir[2] = 32'h0002_0000;
      push(0);
      g = 0;
      while (out_empty[0] && g < 200) begin
         @(posedge clock); @(negedge clock); g++;
      end
      n_cmp += 2;
      if (out_t[0] !== 32'h0002_8000) begin
         n_bad++; $display("FAIL rst_after_t: got %h want 00028000", out_t[0]);
      end
      if (out_hit[0] !== 1'b1) begin
         n_bad++; $display("FAIL rst_after_hit: got %b want 1", out_hit[0]);
      end
      pop(0);
      repeat (120) @(negedge clock);
      n_cmp++;
      if (out_empty[0] !== 1'b1) begin
         n_bad++; $display("FAIL rst_discarded: out_empty got %b want 1", out_empty[0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_fill();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
